sfm_lane_packer: RTL

Parametrised stream repacker between the HCI streamer and the softmax datapath. It converts bus beats of `DATA_WIDTH` bits with byte strobes into dense datapath vectors of `DP_LANES` elements with per-element strobes, buffering partial vectors across beats. An end-of-vector marker flushes the remaining elements as a final partial output beat. The packer lets the datapath lane count be chosen independently of the bus width.

---
 rtl/sfm_pkg.sv | 66 ++++++
 rtl/sfm_lane_mask.sv | 33 +++
 rtl/sfm_lane_packer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sfm_pkg.sv
`default_nettype none
// ============================================================================
// sfm_pkg : shared types and strobe helpers for the softmax stream path
// Rev 1.0 : lane-mask / prefix helpers and packer state encoding
// ============================================================================
package sfm_pkg;

    localparam int SFM_MAX_LANES = 32;
    localparam int SFM_MAX_BPL   = 8;
    localparam int SFM_MAX_BYTES = SFM_MAX_LANES * SFM_MAX_BPL;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } packer_state_e;

    typedef struct packed {
        logic [6:0] len;
        logic       err;
    } lane_prefix_t;

    // A lane counts as valid only when every byte of it is strobed.
    function automatic logic [SFM_MAX_LANES-1:0] lane_mask_from_strb(
        input logic [SFM_MAX_BYTES-1:0] strb,
        input int                       lanes,
        input int                       bytes_per_lane
    );
        logic [SFM_MAX_LANES-1:0] mask;
        mask = '0;
        for (int l = 0; l < SFM_MAX_LANES; l++) begin
            if (l < lanes) begin
                mask[l] = 1'b1;
                for (int b = 0; b < SFM_MAX_BPL; b++) begin
                    if (b < bytes_per_lane) begin
                        mask[l] = mask[l] & strb[l*bytes_per_lane + b];
                    end
                end
            end
        end
        return mask;
    endfunction

    function automatic lane_prefix_t lane_prefix(
        input logic [SFM_MAX_LANES-1:0] mask,
        input int                       lanes
    );
        lane_prefix_t r;
        logic         run;
        r   = '0;
        run = 1'b1;
        for (int l = 0; l < SFM_MAX_LANES; l++) begin
            if (l < lanes) begin
                if (mask[l] && run) begin
                    r.len = r.len + 7'd1;
                end else if (mask[l]) begin
                    r.err = 1'b1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfm_lane_mask.sv
`default_nettype none
// ============================================================================
// sfm_lane_mask : byte strobes -> valid-lane prefix length and gap flag
// Rev 1.0 : initial release
// ============================================================================
module sfm_lane_mask
    import sfm_pkg::*;
#(
    parameter int LANES          = 8,
    parameter int BYTES_PER_LANE = 2,
    parameter int CNT_W          = $clog2(LANES + 1)
) (
    input  logic [LANES*BYTES_PER_LANE-1:0] strb_i,
    output logic [CNT_W-1:0]                cnt_o,
    output logic                            err_o
);

    logic [SFM_MAX_BYTES-1:0] w_strb_ext;
    logic [SFM_MAX_LANES-1:0] w_mask;
    lane_prefix_t             w_pfx;

    always_comb begin
        w_strb_ext                             = '0;
        w_strb_ext[LANES*BYTES_PER_LANE-1:0]   = strb_i;
        w_mask = lane_mask_from_strb(w_strb_ext, LANES, BYTES_PER_LANE);
        w_pfx  = lane_prefix(w_mask, LANES);
    end

    assign cnt_o = w_pfx.len[CNT_W-1:0];
    assign err_o = w_pfx.err;

endmodule
`default_nettype wire

// File: rtl/sfm_lane_packer.sv
`default_nettype none
// ============================================================================
// sfm_lane_packer : repacks strobed bus beats into dense DP_LANES vectors
// Rev 1.0 : initial release
// ============================================================================
module sfm_lane_packer
    import sfm_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    parameter  int WIDTH      = 16,
    parameter  int DP_LANES   = 6,
    localparam int BUS_LANES  = DATA_WIDTH / WIDTH,
    localparam int BUF_LANES  = BUS_LANES + DP_LANES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    input  logic [DATA_WIDTH/8-1:0]   in_strb_i,
    input  logic                      in_last_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DP_LANES*WIDTH-1:0] out_data_o,
    output logic [DP_LANES-1:0]       out_strb_o,
    output logic                      out_last_o,
    output logic                      err_o
);

    localparam int OCC_W = $clog2(BUF_LANES + 1);
    localparam int CNT_W = $clog2(BUS_LANES + 1);
    localparam int BPL   = WIDTH / 8;

    localparam logic [OCC_W-1:0] c_DP_OCC = OCC_W'(DP_LANES);

    packer_state_e    state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] buf_q [BUF_LANES];
    logic [WIDTH-1:0] buf_d [BUF_LANES];
    logic             err_q, err_d;

    logic [CNT_W-1:0] w_push_cnt;
    logic             w_strb_err;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [OCC_W-1:0] w_pop;
    logic [OCC_W-1:0] w_push;
    logic [OCC_W-1:0] w_base;
    logic [OCC_W-1:0] w_out_cnt;

    sfm_lane_mask #(
        .LANES          (BUS_LANES),
        .BYTES_PER_LANE (BPL),
        .CNT_W          (CNT_W)
    ) u_in_mask (
        .strb_i (in_strb_i),
        .cnt_o  (w_push_cnt),
        .err_o  (w_strb_err)
    );

    assign in_ready_o  = (state_q == FILL) && (occ_q <= c_DP_OCC);
    assign out_valid_o = (occ_q >= c_DP_OCC) || (state_q == DRAIN);
    assign out_last_o  = (state_q == DRAIN) && (occ_q <= c_DP_OCC);
    assign err_o       = err_q;

    assign w_in_fire  = in_valid_i && in_ready_o;
    assign w_out_fire = out_valid_o && out_ready_i;
    assign w_out_cnt  = (occ_q < c_DP_OCC) ? occ_q : c_DP_OCC;

    // The closing beat of a vector takes whatever is left, never more than DP_LANES.
    assign w_pop  = w_out_fire ? (out_last_o ? occ_q : c_DP_OCC) : '0;
    assign w_push = w_in_fire ? OCC_W'(w_push_cnt) : '0;
    assign w_base = occ_q - w_pop;

    for (genvar l = 0; l < DP_LANES; l++) begin : g_out_lane
        assign out_strb_o[l]                = (OCC_W'(l) < w_out_cnt);
        assign out_data_o[l*WIDTH +: WIDTH] = out_strb_o[l] ? buf_q[l] : '0;
    end

    // Shift survivors down by the pop amount, then land new lanes at the post-pop tail.
    always_comb begin
        for (int j = 0; j < BUF_LANES; j++) begin
            buf_d[j] = '0;
            for (int s = 0; s < BUF_LANES; s++) begin
                if ((s == j + int'(w_pop)) && (s < int'(occ_q))) begin
                    buf_d[j] = buf_q[s];
                end
            end
            for (int k = 0; k < BUS_LANES; k++) begin
                if ((k < int'(w_push)) && (j == int'(w_base) + k)) begin
                    buf_d[j] = in_data_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (w_in_fire && in_last_i)   state_d = DRAIN;
            DRAIN:   if (w_out_fire && out_last_o) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    assign occ_d = occ_q - w_pop + w_push;
    assign err_d = err_q | (w_in_fire & w_strb_err);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q <= FILL;
            occ_q   <= '0;
            err_q   <= 1'b0;
            for (int j = 0; j < BUF_LANES; j++) begin
                buf_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
            for (int j = 0; j < BUF_LANES; j++) begin
                buf_q[j] <= buf_d[j];
            end
        end
    end

endmodule
`default_nettype wire
